// File: rtl/encoder_width_conv.sv
`timescale 1ns/1ps
// encoder_width_conv
// Transmit-side width converter: takes generator/encoder beats of DWIDTH_IN bits,
// packs (upsize), passes through (equal widths) or slices (downsize) them LSB-first
// into DWIDTH_OUT words, and buffers the words with tlast/tkeep in a single-clock
// FIFO whose registered first-word-fall-through head drives the link-side master.
// A packet whose tlast lands mid-word is flushed as a partial word.
//
// Ports
//   aclk, aresetn         clock, synchronous active-low reset
//   s_axis_t*             input stream (tdata/tvalid/tready/tlast)
//   m_axis_t*             output stream (tdata/tkeep/tlast/tvalid/tready)
//   fifo_count            words held, including the one presented on m_axis
//
// Downsize FSM
//   state    | meaning
//   ST_IDLE  | hold register empty, ready for a new input beat
//   ST_SLICE | emitting slices of the held beat, one per cycle while not full
module encoder_width_conv #(
    parameter int DWIDTH_IN  = 64,
    parameter int DWIDTH_OUT = 64,
    parameter int DEPTH      = 16,
    localparam int LANES     = (DWIDTH_OUT > DWIDTH_IN) ? DWIDTH_OUT / DWIDTH_IN : 1,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DWIDTH_IN-1:0]  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DWIDTH_OUT-1:0] m_axis_tdata,
    output logic [LANES-1:0]      m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [CW-1:0]         fifo_count
);

    localparam int RATIO = (DWIDTH_IN > DWIDTH_OUT) ? DWIDTH_IN / DWIDTH_OUT : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = DWIDTH_OUT + LANES + 1;

    logic                  r_run;
    logic                  w_full;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_s_ready;
    logic                  w_conv_valid;
    logic [DWIDTH_OUT-1:0] w_conv_data;
    logic [LANES-1:0]      w_conv_keep;
    logic                  w_conv_last;

    // Keeps s_axis_tready low while in reset and until the first edge after release.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    assign s_axis_tready = w_s_ready;

    generate
        if (LANES > 1) begin : g_up
            localparam int LW = $clog2(LANES);

            logic [LW-1:0]         r_lane_cnt;
            logic [DWIDTH_OUT-1:0] r_pack;
            logic [DWIDTH_OUT-1:0] w_pack_next;
            logic                  w_acc;
            logic                  w_last_lane;

            assign w_last_lane = (r_lane_cnt == LW'(LANES - 1));
            // A beat that does not complete a word can still be packed while full.
            assign w_s_ready   = r_run && (!w_full || (!w_last_lane && !s_axis_tlast));
            assign w_acc       = s_axis_tvalid && w_s_ready;

            // r_pack is cleared after every write, so lanes above lane_cnt stay zero.
            always_comb begin
                w_pack_next = r_pack;
                w_conv_keep = '0;
                for (int i = 0; i < LANES; i++) begin
                    if (r_lane_cnt == LW'(i)) begin
                        w_pack_next[i*DWIDTH_IN +: DWIDTH_IN] = s_axis_tdata;
                    end
                    w_conv_keep[i] = (LW'(i) <= r_lane_cnt);
                end
            end

            assign w_conv_valid = w_acc && (w_last_lane || s_axis_tlast);
            assign w_conv_data  = w_pack_next;
            assign w_conv_last  = s_axis_tlast;

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    r_lane_cnt <= '0;
                    r_pack     <= '0;
                end else if (w_acc) begin
                    if (w_conv_valid) begin
                        r_lane_cnt <= '0;
                        r_pack     <= '0;
                    end else begin
                        r_lane_cnt <= r_lane_cnt + LW'(1);
                        r_pack     <= w_pack_next;
                    end
                end
            end
        end else if (RATIO > 1) begin : g_down
            localparam int SW = $clog2(RATIO);

            typedef enum logic {
                ST_IDLE,
                ST_SLICE
            } state_t;

            state_t               r_state;
            state_t               w_state_next;
            logic [SW-1:0]        r_slice_cnt;
            logic [SW-1:0]        w_slice_cnt_next;
            logic [DWIDTH_IN-1:0] r_hold;
            logic                 r_hold_last;
            logic                 w_capture;
            logic                 w_final_slice;

            assign w_final_slice = (r_slice_cnt == SW'(RATIO - 1));

            always_comb begin
                w_state_next     = r_state;
                w_slice_cnt_next = r_slice_cnt;
                w_capture        = 1'b0;
                w_s_ready        = 1'b0;
                w_conv_valid     = 1'b0;
                w_conv_last      = 1'b0;
                w_conv_keep      = '1;
                w_conv_data      = '0;
                for (int i = 0; i < RATIO; i++) begin
                    if (r_slice_cnt == SW'(i)) begin
                        w_conv_data = r_hold[i*DWIDTH_OUT +: DWIDTH_OUT];
                    end
                end
                case (r_state)
                    ST_IDLE: begin
                        w_s_ready = r_run;
                        if (s_axis_tvalid && r_run) begin
                            w_capture        = 1'b1;
                            w_slice_cnt_next = '0;
                            w_state_next     = ST_SLICE;
                        end
                    end
                    ST_SLICE: begin
                        // Accepting alongside the final slice sustains one write per cycle.
                        w_s_ready = r_run && w_final_slice && !w_full;
                        if (!w_full) begin
                            w_conv_valid = 1'b1;
                            w_conv_last  = r_hold_last && w_final_slice;
                            if (w_final_slice) begin
                                w_slice_cnt_next = '0;
                                if (s_axis_tvalid && r_run) begin
                                    w_capture    = 1'b1;
                                    w_state_next = ST_SLICE;
                                end else begin
                                    w_state_next = ST_IDLE;
                                end
                            end else begin
                                w_slice_cnt_next = r_slice_cnt + SW'(1);
                            end
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    r_state     <= ST_IDLE;
                    r_slice_cnt <= '0;
                    r_hold      <= '0;
                    r_hold_last <= 1'b0;
                end else begin
                    r_state     <= w_state_next;
                    r_slice_cnt <= w_slice_cnt_next;
                    if (w_capture) begin
                        r_hold      <= s_axis_tdata;
                        r_hold_last <= s_axis_tlast;
                    end
                end
            end
        end else begin : g_pass
            assign w_s_ready    = r_run && !w_full;
            assign w_conv_valid = s_axis_tvalid && w_s_ready;
            assign w_conv_data  = s_axis_tdata;
            assign w_conv_keep  = '1;
            assign w_conv_last  = s_axis_tlast;
        end
    endgenerate

    // FIFO. The output registers always mirror the head entry, which keeps its
    // slot (and its place in fifo_count) until it is read.
    logic [WW-1:0]         r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         w_rd_ptr_next;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_count_next;
    logic [WW-1:0]         w_wword;
    logic [WW-1:0]         w_head;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [LANES-1:0]      r_out_keep;
    logic [DWIDTH_OUT-1:0] r_out_data;

    assign w_full        = (r_count == CW'(DEPTH));
    assign w_wr          = w_conv_valid && !w_full;
    assign w_rd          = r_out_valid && m_axis_tready;
    assign w_wword       = {w_conv_last, w_conv_keep, w_conv_data};
    assign w_rd_ptr_next = r_rd_ptr + AW'(w_rd);
    assign w_count_next  = r_count + CW'(w_wr) - CW'(w_rd);

    // The write pointer only equals the next head index while writing when that
    // head is the word being written now (empty or draining to empty).
    always_comb begin
        if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head = w_wword;
        end else begin
            w_head = r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge aclk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wword;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_keep  <= '0;
            r_out_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_out_valid <= (w_count_next != '0);
            if (w_count_next != '0) begin
                {r_out_last, r_out_keep, r_out_data} <= w_head;
            end else begin
                r_out_last <= 1'b0;
                r_out_keep <= '0;
                r_out_data <= '0;
            end
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_valid;
    assign fifo_count    = r_count;

endmodule

// File: tb/tb_encoder_width_conv.sv
`timescale 1ns/1ps
// tb_encoder_width_conv
// Three instances share clock and reset: 32->128 upsize, 128->32 downsize and
// 64->64 pass-through with DEPTH=4. Expected words are queued as stimulus is
// driven and checked by per-instance monitors on the falling edge; the test
// tasks check handshake timing, occupancy and stall behaviour inline.
module tb_encoder_width_conv;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [31:0]  up_s_tdata;
    logic         up_s_tvalid, up_s_tready, up_s_tlast;
    logic [127:0] up_m_tdata;
    logic [3:0]   up_m_tkeep;
    logic         up_m_tlast, up_m_tvalid, up_m_tready;
    logic [4:0]   up_fifo_count;

    logic [127:0] dn_s_tdata;
    logic         dn_s_tvalid, dn_s_tready, dn_s_tlast;
    logic [31:0]  dn_m_tdata;
    logic [0:0]   dn_m_tkeep;
    logic         dn_m_tlast, dn_m_tvalid, dn_m_tready;
    logic [4:0]   dn_fifo_count;

    logic [63:0]  eq_s_tdata;
    logic         eq_s_tvalid, eq_s_tready, eq_s_tlast;
    logic [63:0]  eq_m_tdata;
    logic [0:0]   eq_m_tkeep;
    logic         eq_m_tlast, eq_m_tvalid, eq_m_tready;
    logic [2:0]   eq_fifo_count;

    encoder_width_conv #(.DWIDTH_IN(32), .DWIDTH_OUT(128), .DEPTH(16)) u_up (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(up_s_tdata), .s_axis_tvalid(up_s_tvalid),
        .s_axis_tready(up_s_tready), .s_axis_tlast(up_s_tlast),
        .m_axis_tdata(up_m_tdata), .m_axis_tkeep(up_m_tkeep),
        .m_axis_tlast(up_m_tlast), .m_axis_tvalid(up_m_tvalid),
        .m_axis_tready(up_m_tready), .fifo_count(up_fifo_count)
    );

    encoder_width_conv #(.DWIDTH_IN(128), .DWIDTH_OUT(32), .DEPTH(16)) u_dn (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(dn_s_tdata), .s_axis_tvalid(dn_s_tvalid),
        .s_axis_tready(dn_s_tready), .s_axis_tlast(dn_s_tlast),
        .m_axis_tdata(dn_m_tdata), .m_axis_tkeep(dn_m_tkeep),
        .m_axis_tlast(dn_m_tlast), .m_axis_tvalid(dn_m_tvalid),
        .m_axis_tready(dn_m_tready), .fifo_count(dn_fifo_count)
    );

    encoder_width_conv #(.DWIDTH_IN(64), .DWIDTH_OUT(64), .DEPTH(4)) u_eq (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(eq_s_tdata), .s_axis_tvalid(eq_s_tvalid),
        .s_axis_tready(eq_s_tready), .s_axis_tlast(eq_s_tlast),
        .m_axis_tdata(eq_m_tdata), .m_axis_tkeep(eq_m_tkeep),
        .m_axis_tlast(eq_m_tlast), .m_axis_tvalid(eq_m_tvalid),
        .m_axis_tready(eq_m_tready), .fifo_count(eq_fifo_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected words as {tdata, tkeep, tlast}.
    logic [132:0] up_q[$];
    logic [33:0]  dn_q[$];
    logic [65:0]  eq_q[$];
    logic [132:0] up_e;
    logic [33:0]  dn_e;
    logic [65:0]  eq_e;

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && up_m_tvalid === 1'b1 && up_m_tready === 1'b1) begin
            n_checks++;
            if (up_q.size() == 0) begin
                n_fail++;
                $display("FAIL up_out unexpected word data=%h keep=%h last=%b, required none",
                         up_m_tdata, up_m_tkeep, up_m_tlast);
            end else begin
                up_e = up_q.pop_front();
                if ({up_m_tdata, up_m_tkeep, up_m_tlast} !== up_e) begin
                    n_fail++;
                    $display("FAIL up_out got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                             up_m_tdata, up_m_tkeep, up_m_tlast, up_e[132:5], up_e[4:1], up_e[0]);
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && dn_m_tvalid === 1'b1 && dn_m_tready === 1'b1) begin
            n_checks++;
            if (dn_q.size() == 0) begin
                n_fail++;
                $display("FAIL dn_out unexpected word data=%h last=%b, required none",
                         dn_m_tdata, dn_m_tlast);
            end else begin
                dn_e = dn_q.pop_front();
                if ({dn_m_tdata, dn_m_tkeep, dn_m_tlast} !== dn_e) begin
                    n_fail++;
                    $display("FAIL dn_out got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                             dn_m_tdata, dn_m_tkeep, dn_m_tlast, dn_e[33:2], dn_e[1], dn_e[0]);
                end
            end
        end
    end

    always @(negedge aclk) begin
        if (aresetn === 1'b1 && eq_m_tvalid === 1'b1 && eq_m_tready === 1'b1) begin
            n_checks++;
            if (eq_q.size() == 0) begin
                n_fail++;
                $display("FAIL eq_out unexpected word data=%h, required none", eq_m_tdata);
            end else begin
                eq_e = eq_q.pop_front();
                if ({eq_m_tdata, eq_m_tkeep, eq_m_tlast} !== eq_e) begin
                    n_fail++;
                    $display("FAIL eq_out got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                             eq_m_tdata, eq_m_tkeep, eq_m_tlast, eq_e[65:2], eq_e[1], eq_e[0]);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive phase is just after a rising edge; inputs change only there.
    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    // Each send task starts and ends in the drive phase; returns just after the handshake edge.
    task automatic up_beat(input logic [31:0] d, input logic l);
        int t;
        up_s_tdata = d; up_s_tlast = l; up_s_tvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (up_s_tready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL up_handshake timeout got tready=%b, required 1", up_s_tready);
        end
        sync();
        up_s_tvalid = 1'b0; up_s_tlast = 1'b0;
    endtask

    task automatic dn_beat(input logic [127:0] d, input logic l);
        int t;
        dn_s_tdata = d; dn_s_tlast = l; dn_s_tvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (dn_s_tready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL dn_handshake timeout got tready=%b, required 1", dn_s_tready);
        end
        sync();
        dn_s_tvalid = 1'b0; dn_s_tlast = 1'b0;
    endtask

    task automatic eq_beat(input logic [63:0] d, input logic l);
        int t;
        eq_s_tdata = d; eq_s_tlast = l; eq_s_tvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (eq_s_tready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
        if (t >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL eq_handshake timeout got tready=%b, required 1", eq_s_tready);
        end
        sync();
        eq_s_tvalid = 1'b0; eq_s_tlast = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        up_s_tvalid = 1'b1; dn_s_tvalid = 1'b1; eq_s_tvalid = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (up_s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_up_tready got %b required 0", up_s_tready); end
        n_checks++; if (dn_s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_dn_tready got %b required 0", dn_s_tready); end
        n_checks++; if (eq_s_tready !== 1'b0) begin n_fail++; $display("FAIL rst_eq_tready got %b required 0", eq_s_tready); end
        n_checks++; if (up_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_up_tvalid got %b required 0", up_m_tvalid); end
        n_checks++; if (dn_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_dn_tvalid got %b required 0", dn_m_tvalid); end
        n_checks++; if (eq_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_eq_tvalid got %b required 0", eq_m_tvalid); end
        n_checks++; if (up_fifo_count !== 5'd0) begin n_fail++; $display("FAIL rst_up_count got %0d required 0", up_fifo_count); end
        n_checks++; if (eq_fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_eq_count got %0d required 0", eq_fifo_count); end
        n_checks++;
        if ({up_m_tdata, up_m_tkeep, up_m_tlast} !== 133'd0) begin
            n_fail++;
            $display("FAIL rst_up_outregs got data=%h keep=%h last=%b required all 0", up_m_tdata, up_m_tkeep, up_m_tlast);
        end
        sync();
        aresetn = 1'b1;
        up_s_tvalid = 1'b0; dn_s_tvalid = 1'b0; eq_s_tvalid = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (up_s_tready !== 1'b1) begin n_fail++; $display("FAIL rel_up_tready got %b required 1", up_s_tready); end
        n_checks++; if (dn_s_tready !== 1'b1) begin n_fail++; $display("FAIL rel_dn_tready got %b required 1", dn_s_tready); end
        n_checks++; if (eq_s_tready !== 1'b1) begin n_fail++; $display("FAIL rel_eq_tready got %b required 1", eq_s_tready); end
        sync();
    endtask

    task automatic test_upsize();
        up_q.push_back({128'h44444444_33333333_22222222_11111111, 4'hF, 1'b1});
        up_beat(32'h11111111, 1'b0);
        up_beat(32'h22222222, 1'b0);
        up_beat(32'h33333333, 1'b0);
        @(negedge aclk);
        n_checks++; if (up_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL up_early_valid got %b required 0", up_m_tvalid); end
        sync();
        up_beat(32'h44444444, 1'b1);
        @(negedge aclk);
        n_checks++; if (up_m_tvalid !== 1'b1) begin n_fail++; $display("FAIL up_latency got tvalid=%b required 1", up_m_tvalid); end
        sync();
        repeat (3) sync();
        n_checks++; if (up_q.size() != 0) begin n_fail++; $display("FAIL up_drain got %0d pending required 0", up_q.size()); end
    endtask

    task automatic test_upsize_partial();
        up_q.push_back({128'h0000000B_0000000A, 4'h3, 1'b1});
        up_q.push_back({128'h0000000C, 4'h1, 1'b1});
        up_beat(32'h0000000A, 1'b0);
        up_beat(32'h0000000B, 1'b1);
        up_beat(32'h0000000C, 1'b1);
        repeat (4) sync();
        n_checks++; if (up_q.size() != 0) begin n_fail++; $display("FAIL up_partial_drain got %0d pending required 0", up_q.size()); end
    endtask

    task automatic test_downsize();
        dn_q.push_back({32'h0000AAAA, 1'b1, 1'b0});
        dn_q.push_back({32'h0000BBBB, 1'b1, 1'b0});
        dn_q.push_back({32'h0000CCCC, 1'b1, 1'b0});
        dn_q.push_back({32'h0000DDDD, 1'b1, 1'b1});
        dn_beat(128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, 1'b1);
        @(negedge aclk);
        n_checks++; if (dn_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL dn_lat1 got tvalid=%b required 0", dn_m_tvalid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            n_checks++;
            if (dn_m_tvalid !== 1'b1) begin n_fail++; $display("FAIL dn_stream slot %0d got tvalid=%b required 1", i, dn_m_tvalid); end
        end
        @(negedge aclk);
        n_checks++; if (dn_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL dn_after got tvalid=%b required 0", dn_m_tvalid); end
        sync();
        n_checks++; if (dn_q.size() != 0) begin n_fail++; $display("FAIL dn_drain got %0d pending required 0", dn_q.size()); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            dn_q.push_back({32'h0000_0100 + 32'(i), 1'b1, (i == 8)});
        end
        dn_beat(128'h00000104_00000103_00000102_00000101, 1'b0);
        dn_beat(128'h00000108_00000107_00000106_00000105, 1'b1);
        // Last slice of the first beat, then four slices of the second with no gap.
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            n_checks++;
            if (dn_m_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_stream slot %0d got tvalid=%b required 1", i, dn_m_tvalid); end
        end
        @(negedge aclk);
        n_checks++; if (dn_m_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_after got tvalid=%b required 0", dn_m_tvalid); end
        sync();
        n_checks++; if (dn_q.size() != 0) begin n_fail++; $display("FAIL b2b_drain got %0d pending required 0", dn_q.size()); end
    endtask

    task automatic test_backpressure();
        int k;
        k = 0;
        eq_m_tready = 1'b0;
        eq_s_tvalid = 1'b1;
        eq_s_tlast  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            eq_s_tdata = 64'h1000 + 64'(k);
            @(negedge aclk);
            if (eq_s_tready === 1'b1) begin
                eq_q.push_back({64'h1000 + 64'(k), 1'b1, 1'b0});
                k++;
            end
            sync();
            if (k == 6) break;
        end
        eq_s_tvalid = 1'b0;
        @(negedge aclk);
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_accepted got %0d required 4", k); end
        n_checks++; if (eq_fifo_count !== 3'd4) begin n_fail++; $display("FAIL bp_count_full got %0d required 4", eq_fifo_count); end
        n_checks++; if (eq_s_tready !== 1'b0) begin n_fail++; $display("FAIL bp_tready_full got %b required 0", eq_s_tready); end
        n_checks++;
        if (eq_m_tvalid !== 1'b1 || eq_m_tdata !== 64'h1000) begin
            n_fail++; $display("FAIL bp_head_hold got valid=%b data=%h required 1 and 1000", eq_m_tvalid, eq_m_tdata);
        end
        sync();
        eq_m_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            n_checks++;
            if (eq_fifo_count !== 3'(4 - i)) begin n_fail++; $display("FAIL bp_count_drain step %0d got %0d required %0d", i, eq_fifo_count, 4 - i); end
        end
        n_checks++; if (eq_s_tready !== 1'b1) begin n_fail++; $display("FAIL bp_release got tready=%b required 1", eq_s_tready); end
        sync();
        eq_q.push_back({64'h1004, 1'b1, 1'b0});
        eq_beat(64'h1004, 1'b0);
        eq_q.push_back({64'h1005, 1'b1, 1'b1});
        eq_beat(64'h1005, 1'b1);
        repeat (4) sync();
        n_checks++; if (eq_q.size() != 0) begin n_fail++; $display("FAIL bp_drain got %0d pending required 0", eq_q.size()); end
    endtask

    task automatic test_reset_midpacket();
        up_beat(32'h00000055, 1'b0);
        up_beat(32'h00000066, 1'b0);
        aresetn = 1'b0;
        sync();
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            n_checks++;
            if (up_m_tvalid !== 1'b0 || up_fifo_count !== 5'd0) begin
                n_fail++; $display("FAIL midrst_idle got valid=%b count=%0d required 0 and 0", up_m_tvalid, up_fifo_count);
            end
            sync();
        end
        up_q.push_back({128'h00000004_00000003_00000002_00000001, 4'hF, 1'b1});
        up_beat(32'h00000001, 1'b0);
        up_beat(32'h00000002, 1'b0);
        up_beat(32'h00000003, 1'b0);
        up_beat(32'h00000004, 1'b1);
        repeat (4) sync();
        n_checks++; if (up_q.size() != 0) begin n_fail++; $display("FAIL midrst_drain got %0d pending required 0", up_q.size()); end
    endtask

    initial begin
        aresetn     = 1'b0;
        up_s_tdata  = '0; up_s_tlast = 1'b0; up_s_tvalid = 1'b0; up_m_tready = 1'b1;
        dn_s_tdata  = '0; dn_s_tlast = 1'b0; dn_s_tvalid = 1'b0; dn_m_tready = 1'b1;
        eq_s_tdata  = '0; eq_s_tlast = 1'b0; eq_s_tvalid = 1'b0; eq_m_tready = 1'b1;
        test_reset();
        test_upsize();
        test_upsize_partial();
        test_downsize();
        test_back_to_back();
        test_backpressure();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_width_conv.md
Name: encoder_width_conv

Overview:
- Transmit-side counterpart of the decoder width-conversion FIFO in the traffic engine.
- Takes generator/encoder beats at DWIDTH_IN and converts them to DWIDTH_OUT by integer ratio (pack, pass-through or unpack), LSB-first.
- Buffers converted words, with their tlast/tkeep, in a single-clock FIFO that feeds the link-side AXI-Stream master.
- Honours s_axis_tlast: a packet ending mid-word is flushed as a partial word.

Parameters:
- DWIDTH_IN, 64, input beat width in bits; DWIDTH_OUT/DWIDTH_IN or DWIDTH_IN/DWIDTH_OUT is a power-of-2 integer.
- DWIDTH_OUT, 64, output beat width in bits.
- DEPTH, 16, FIFO depth in DWIDTH_OUT words; power of 2, ≥2.
- Derived LANES = DWIDTH_OUT/DWIDTH_IN when upsizing, else 1.

Ports:
- aclk  in  1  single clock.
- aresetn  in  1  synchronous, active-low reset; sampled on rising edge of aclk.
- s_axis_tdata  in  DWIDTH_IN  input beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  last beat of packet.
- m_axis_tdata  out  DWIDTH_OUT  output word.
- m_axis_tkeep  out  LANES  per-DWIDTH_IN-lane valid mask (upsize); constant 1 otherwise.
- m_axis_tlast  out  1  last word of packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy in words.

Behaviour:
Reset (aresetn=0 at an edge):
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, fifo_count=0, s_axis_tready=0.
- Lane counter, pack/hold registers and FIFO pointers cleared.
- Reset mid-packet discards all partial and buffered data; no flush.
- s_axis_tready=1 from the first cycle after reset release.

FIFO:
- Write when conv_valid && !full. Full blocks writes even if a read happens in the same cycle.
- Read when m_axis_tvalid && m_axis_tready.
- Simultaneous read+write leaves fifo_count unchanged.
- Output is a registered first-word-fall-through stage: word written in cycle N gives m_axis_tvalid=1 in cycle N+1 if the FIFO was empty.
- Output holds data/keep/last stable while tvalid && !tready.
- Underflow and overflow are impossible by construction.

Upsize (LANES>1):
- lane_cnt 0..LANES-1. Accepted beat k goes to bits [k*DWIDTH_IN +: DWIDTH_IN].
- FIFO write, combinational in the accepting cycle, occurs when lane_cnt==LANES-1 or s_axis_tlast=1.
- Written word: tkeep has bits 0..lane_cnt set, unused lanes zero, tlast = s_axis_tlast.
- lane_cnt returns to 0 after each write.
- s_axis_tready = !full || (lane_cnt != LANES-1 && !s_axis_tlast).
- Single-beat packet with tlast gives tkeep=1, tdata = beat zero-extended.

Pass-through (equal widths):
- Direct FIFO write; tkeep=1; s_axis_tready = !full.

Downsize (RATIO=DWIDTH_IN/DWIDTH_OUT):
- States IDLE / SLICE.
- IDLE: s_axis_tready=1; an accepted beat is captured into the hold register with its tlast, slice_cnt=0, go to SLICE.
- SLICE: when !full, write hold[slice_cnt*DWIDTH_OUT +: DWIDTH_OUT] and increment slice_cnt. tlast = held_tlast && slice_cnt==RATIO-1.
- After the last slice is written: go to IDLE. If s_axis_tvalid in that same cycle, capture the next beat and stay in SLICE with slice_cnt=0 (back-to-back, one write per cycle sustained).
- s_axis_tready = IDLE || (SLICE && slice_cnt==RATIO-1 && !full).
- First m_axis_tvalid occurs 2 cycles after the input handshake.
- A full FIFO stalls slicing without losing data.

Test Plan:
- Reset: hold aresetn=0 3 cycles with s_axis_tvalid=1 -> s_axis_tready=0, m_axis_tvalid=0, fifo_count=0; tready=1 in the cycle after release.
- Upsize 32->128: beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, tlast on 4th -> one word 0x44444444_33333333_22222222_11111111, tkeep=4'hF, tlast=1, valid 1 cycle after 4th handshake.
- Upsize partial flush: 32->128, beats 0xA, 0xB with tlast on 2nd -> word 0x...0000000B_0000000A (upper lanes 0), tkeep=4'h3, tlast=1; next packet starts at lane 0.
- Downsize 128->32: one beat 0xDDDD_CCCC_BBBB_AAAA (32-bit lanes), tlast=1, m_axis_tready=1 -> 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD on consecutive cycles starting 2 cycles after the handshake; tlast only on 0xDDDD.
- Backpressure/full: DEPTH=4, equal widths, m_axis_tready=0, 6 beats offered -> 4 accepted, fifo_count=4, s_axis_tready=0. Then tready=1 -> words emitted in order, count decrements, stall released, no loss or duplication.
- Reset mid-packet: 32->128 after 2 beats, pulse aresetn=0 1 cycle -> no output word; next 4-beat packet emits exactly one correct word, tkeep=4'hF.
